// File: rtl/module_mem_pkg.sv
// module_mem_pkg: opcode constants and dmem FSM states shared by the MEM stage.
package module_mem_pkg;
  localparam logic [10:0] OP_LDUR = 11'h7C2;
  localparam logic [10:0] OP_STUR = 11'h7C0;
  localparam logic [7:0]  OP_CBZ8 = 8'hB4;
  localparam logic [4:0]  XZR     = 5'd31;
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} dmem_state_t;
endpackage

// File: rtl/mem_dmem_if.sv
// mem_dmem_if: req/gnt/rvalid data-memory FSM; latches one access and
// reports completion with a combinational done pulse.
module mem_dmem_if
  import module_mem_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               i_start,
  input  logic               i_we,
  input  logic [DATA_W-1:0]  i_addr,
  input  logic [DATA_W-1:0]  i_wdata,
  input  logic [RADDR_W-1:0] i_waddr,
  output logic               o_idle,
  output logic               o_done,
  output logic               o_load,
  output logic [RADDR_W-1:0] o_waddr,
  output logic               o_req,
  output logic               o_we,
  output logic [DATA_W-1:0]  o_addr,
  output logic [DATA_W-1:0]  o_wdata,
  input  logic               i_gnt,
  input  logic               i_rvalid
);
  dmem_state_t        r_state;
  logic               r_we;
  logic [DATA_W-1:0]  r_addr;
  logic [DATA_W-1:0]  r_wdata;
  logic [RADDR_W-1:0] r_waddr;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_waddr <= '0;
    end else if (r_state == S_IDLE && i_start) begin
      r_state <= S_REQ;
      r_we    <= i_we;
      r_addr  <= i_addr;
      r_wdata <= i_wdata;
      r_waddr <= i_waddr;
    end else if (r_state == S_REQ && i_gnt) begin
      r_state <= r_we ? S_IDLE : S_RESP;
    end else if (r_state == S_RESP && i_rvalid) begin
      r_state <= S_IDLE;
    end
  end
  // rvalid only counts once the load has been granted
  assign o_done  = (r_state == S_REQ && i_gnt && r_we) || (r_state == S_RESP && i_rvalid);
  assign o_idle  = r_state == S_IDLE;
  assign o_load  = !r_we;
  assign o_waddr = r_waddr;
  assign o_req   = r_state == S_REQ;
  assign o_we    = r_we;
  assign o_addr  = r_addr;
  assign o_wdata = r_wdata;
endmodule

// File: rtl/module_mem.sv
// module_mem: LEGv8 MEM stage; decodes the EX bundle, runs LDUR/STUR through
// mem_dmem_if, resolves CBZ and drives the registered WB bundle.
module module_mem
  import module_mem_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5,
  parameter int OP_W    = 11
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               mem_valid_i,
  output logic               mem_ready_o,
  input  logic [OP_W-1:0]    mem_opcode_i,
  input  logic               mem_zeroflag_i,
  input  logic [DATA_W-1:0]  mem_result_i,
  input  logic [DATA_W-1:0]  mem_reg2_i,
  input  logic [RADDR_W-1:0] mem_waddr_i,
  output logic               dmem_req_o,
  output logic               dmem_we_o,
  output logic [DATA_W-1:0]  dmem_addr_o,
  output logic [DATA_W-1:0]  dmem_wdata_o,
  input  logic               dmem_gnt_i,
  input  logic               dmem_rvalid_i,
  input  logic [DATA_W-1:0]  dmem_rdata_i,
  output logic               wb_valid_o,
  output logic               wb_we_o,
  output logic [RADDR_W-1:0] wb_waddr_o,
  output logic [DATA_W-1:0]  wb_wdata_o,
  output logic               br_taken_o,
  output logic               align_err_o
);
  logic               w_ld, w_st, w_cbz, w_mem, w_mis, w_acc, w_start;
  logic               w_idle, w_done, w_load;
  logic [RADDR_W-1:0] w_done_waddr;
  assign w_ld    = mem_opcode_i == OP_LDUR;
  assign w_st    = mem_opcode_i == OP_STUR;
  assign w_cbz   = mem_opcode_i[10:3] == OP_CBZ8;
  assign w_mem   = w_ld || w_st;
  assign w_mis   = |mem_result_i[1:0];
  assign w_acc   = mem_valid_i && mem_ready_o;
  assign w_start = w_acc && w_mem && !w_mis;
  assign mem_ready_o = w_idle;
  mem_dmem_if #(.DATA_W(DATA_W), .RADDR_W(RADDR_W)) u_dmem (
    .clock    (clock),
    .reset    (reset),
    .i_start  (w_start),
    .i_we     (w_st),
    .i_addr   (mem_result_i),
    .i_wdata  (mem_reg2_i),
    .i_waddr  (mem_waddr_i),
    .o_idle   (w_idle),
    .o_done   (w_done),
    .o_load   (w_load),
    .o_waddr  (w_done_waddr),
    .o_req    (dmem_req_o),
    .o_we     (dmem_we_o),
    .o_addr   (dmem_addr_o),
    .o_wdata  (dmem_wdata_o),
    .i_gnt    (dmem_gnt_i),
    .i_rvalid (dmem_rvalid_i)
  );
  // completion and acceptance are exclusive: ready is low while an access is open
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wb_valid_o  <= 1'b0;
      wb_we_o     <= 1'b0;
      wb_waddr_o  <= '0;
      wb_wdata_o  <= '0;
      br_taken_o  <= 1'b0;
      align_err_o <= 1'b0;
    end else begin
      wb_valid_o <= 1'b0;
      br_taken_o <= 1'b0;
      if (w_done) begin
        wb_valid_o <= 1'b1;
        wb_we_o    <= w_load && w_done_waddr != XZR;
        wb_waddr_o <= w_done_waddr;
        wb_wdata_o <= dmem_rdata_i;
      end else if (w_acc && !w_start) begin
        wb_valid_o <= 1'b1;
        wb_we_o    <= !w_mem && !w_cbz && mem_waddr_i != XZR;
        wb_waddr_o <= mem_waddr_i;
        wb_wdata_o <= mem_result_i;
        br_taken_o <= w_cbz && mem_zeroflag_i;
        if (w_mem) align_err_o <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_module_mem.sv
// tb_module_mem: directed stimulus for module_mem, checked every cycle against
// a transaction-level model plus hand-computed literal expectations.
module tb_module_mem;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid = 1'b0;
  logic [10:0] op = '0;
  logic        zf = 1'b0;
  logic [31:0] res = '0;
  logic [31:0] reg2 = '0;
  logic [4:0]  waddr = '0;
  logic        gnt = 1'b0;
  logic        rvalid = 1'b0;
  logic [31:0] rdata = '0;
  logic        ready, req, dwe, wb_valid, wb_we, br, align;
  logic [31:0] daddr, dwdata, wb_wdata;
  logic [4:0]  wb_waddr;
  int n_chk = 0;
  int n_err = 0;

  module_mem dut (
    .clock(clk), .reset(rst_n),
    .mem_valid_i(valid), .mem_ready_o(ready), .mem_opcode_i(op),
    .mem_zeroflag_i(zf), .mem_result_i(res), .mem_reg2_i(reg2), .mem_waddr_i(waddr),
    .dmem_req_o(req), .dmem_we_o(dwe), .dmem_addr_o(daddr), .dmem_wdata_o(dwdata),
    .dmem_gnt_i(gnt), .dmem_rvalid_i(rvalid), .dmem_rdata_i(rdata),
    .wb_valid_o(wb_valid), .wb_we_o(wb_we), .wb_waddr_o(wb_waddr), .wb_wdata_o(wb_wdata),
    .br_taken_o(br), .align_err_o(align)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: one pending access record; retirements computed from the ISA rules.
  logic        m_busy = 0, m_granted = 0, m_store = 0, m_align = 0;
  logic [31:0] m_addr = 0, m_wdata = 0;
  logic [4:0]  m_waddr = 0;
  logic        e_valid = 0, e_we = 0, e_br = 0;
  logic [4:0]  e_waddr = 0;
  logic [31:0] e_wdata = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 0; m_granted = 0; m_align = 0; e_valid = 0; e_br = 0;
    end else begin
      e_valid = 0; e_br = 0;
      if (m_busy) begin
        if (!m_granted && gnt && m_store) begin
          m_busy = 0; e_valid = 1; e_we = 0; e_waddr = m_waddr; e_wdata = 'x;
        end else if (!m_granted && gnt) begin
          m_granted = 1;
        end else if (m_granted && rvalid) begin
          m_busy = 0; e_valid = 1; e_we = (m_waddr != 31); e_waddr = m_waddr; e_wdata = rdata;
        end
      end else if (valid) begin
        logic is_ld, is_st, is_cbz;
        is_ld = (op == 11'h7C2);
        is_st = (op == 11'h7C0);
        is_cbz = (op[10:3] == 8'hB4);
        if ((is_ld || is_st) && res[1:0] == 0) begin
          m_busy = 1; m_granted = 0; m_store = is_st;
          m_addr = res; m_wdata = reg2; m_waddr = waddr;
        end else begin
          e_valid = 1; e_waddr = waddr; e_wdata = res;
          e_we = !(is_ld || is_st || is_cbz) && waddr != 31;
          e_br = is_cbz && zf;
          if (is_ld || is_st) m_align = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("ready", 32'(ready), 32'(!m_busy));
    chk("dmem_req", 32'(req), 32'(m_busy && !m_granted));
    chk("wb_valid", 32'(wb_valid), 32'(e_valid));
    chk("br_taken", 32'(br), 32'(e_br));
    chk("align_err", 32'(align), 32'(m_align));
    if (m_busy && !m_granted) begin
      chk("dmem_we", 32'(dwe), 32'(m_store));
      chk("dmem_addr", daddr, m_addr);
      if (m_store) chk("dmem_wdata", dwdata, m_wdata);
    end
    if (e_valid) begin
      chk("wb_we", 32'(wb_we), 32'(e_we));
      chk("wb_waddr", 32'(wb_waddr), 32'(e_waddr));
      if (e_we) chk("wb_wdata", wb_wdata, e_wdata);
    end
  end

  // present one bundle for one cycle; returns at the negedge after acceptance
  task automatic issue(input logic [10:0] o, input logic z, input logic [31:0] r,
                       input logic [31:0] d, input logic [4:0] w);
    @(negedge clk);
    valid = 1; op = o; zf = z; res = r; reg2 = d; waddr = w;
    @(negedge clk);
    valid = 0;
  endtask

  task automatic pulse_gnt(input logic rv, input logic [31:0] rd);
    gnt = 1; rvalid = rv; rdata = rd;
    @(negedge clk);
    gnt = 0; rvalid = 0;
  endtask

  task automatic pulse_rvalid(input logic [31:0] rd);
    rvalid = 1; rdata = rd;
    @(negedge clk);
    rvalid = 0;
  endtask

  initial begin
    #12;
    chk("rst_ready", 32'(ready), 1);
    chk("rst_req", 32'(req), 0);
    chk("rst_wb_valid", 32'(wb_valid), 0);
    chk("rst_align", 32'(align), 0);
    rst_n = 1;
    // 1: ORR
    issue(11'h550, 0, 32'h3, 0, 5'd5);
    chk("orr_valid", 32'(wb_valid), 1);
    chk("orr_we", 32'(wb_we), 1);
    chk("orr_waddr", 32'(wb_waddr), 5);
    chk("orr_wdata", wb_wdata, 32'h3);
    // 2: LDUR with delayed gnt and rvalid; rvalid during gnt cycle is ignored
    issue(11'h7C2, 0, 32'h40, 0, 5'd2);
    repeat (2) begin
      chk("ld_req_hold", 32'(req), 1);
      chk("ld_addr_hold", daddr, 32'h40);
      chk("ld_ready_lo", 32'(ready), 0);
      @(negedge clk);
    end
    pulse_gnt(1, 32'hBAD0BAD0);
    chk("ld_resp_req", 32'(req), 0);
    chk("ld_resp_wb", 32'(wb_valid), 0);
    repeat (2) begin
      chk("ld_resp_ready", 32'(ready), 0);
      @(negedge clk);
    end
    pulse_rvalid(32'hDEADBEEF);
    chk("ld_valid", 32'(wb_valid), 1);
    chk("ld_we", 32'(wb_we), 1);
    chk("ld_waddr", 32'(wb_waddr), 2);
    chk("ld_wdata", wb_wdata, 32'hDEADBEEF);
    // 3: STUR granted immediately
    issue(11'h7C0, 0, 32'h44, 32'h1234, 5'd7);
    chk("st_dwe", 32'(dwe), 1);
    chk("st_addr", daddr, 32'h44);
    chk("st_wdata", dwdata, 32'h1234);
    pulse_gnt(0, 0);
    chk("st_valid", 32'(wb_valid), 1);
    chk("st_we", 32'(wb_we), 0);
    // 4: CBZ taken / not taken
    issue(11'h5A0, 1, 0, 0, 5'd3);
    chk("cbz1_br", 32'(br), 1);
    chk("cbz1_we", 32'(wb_we), 0);
    issue(11'h5A0, 0, 0, 0, 5'd3);
    chk("cbz0_br", 32'(br), 0);
    chk("cbz0_valid", 32'(wb_valid), 1);
    // stray handshakes while idle
    @(negedge clk);
    gnt = 1; rvalid = 1; rdata = 32'h55;
    @(negedge clk);
    gnt = 0; rvalid = 0;
    chk("idle_stray_wb", 32'(wb_valid), 0);
    // 5: misaligned LDUR, then align_err stays set
    issue(11'h7C2, 0, 32'h41, 0, 5'd4);
    chk("mis_req", 32'(req), 0);
    chk("mis_align", 32'(align), 1);
    chk("mis_we", 32'(wb_we), 0);
    issue(11'h458, 0, 32'h9, 0, 5'd6);
    chk("mis_sticky", 32'(align), 1);
    // back-to-back ALU ops
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      valid = 1; op = 11'h458; res = 32'h100 + i; waddr = 5'(8 + i);
    end
    @(negedge clk);
    valid = 0;
    chk("b2b_last", wb_wdata, 32'h103);
    // aligned load to XZR: retires without register write
    issue(11'h7C2, 0, 32'h80, 0, 5'd31);
    pulse_gnt(0, 0);
    pulse_rvalid(32'hCAFE0000);
    chk("xzr_ld_valid", 32'(wb_valid), 1);
    chk("xzr_ld_we", 32'(wb_we), 0);
    // 6: reset during RESP
    issue(11'h7C2, 0, 32'h48, 0, 5'd9);
    pulse_gnt(0, 0);
    #2 rst_n = 0;
    #1;
    chk("rst_mid_req", 32'(req), 0);
    chk("rst_mid_ready", 32'(ready), 1);
    chk("rst_mid_wb", 32'(wb_valid), 0);
    chk("rst_mid_align", 32'(align), 0);
    @(negedge clk);
    #2 rst_n = 1;
    @(negedge clk);
    pulse_rvalid(32'h77);
    chk("late_rvalid_wb", 32'(wb_valid), 0);
    issue(11'h458, 0, 32'h5, 0, 5'd31);
    chk("xzr_add_valid", 32'(wb_valid), 1);
    chk("xzr_add_we", 32'(wb_we), 0);
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
